// File: rtl/mbus_sleep_req_ctrl_pkg.sv
// Shared types and constants for the MBus sleep-request controller.
//   state_e      : controller FSM state, 2-bit, encoding fixed for debug readout
//   NUM_WAKE_SRC : number of asynchronous wake sources handled
package mbus_sleep_pkg;

    localparam int unsigned NUM_WAKE_SRC = 3;
    localparam int unsigned STATE_W      = 2;

    typedef enum logic [STATE_W-1:0] {
        ACTIVE    = 2'd0,
        IDLE_WAIT = 2'd1,
        REQ       = 2'd2,
        SLEEPING  = 2'd3
    } state_e;

endpackage

// File: rtl/mbus_sleep_req_ctrl_if.sv
// Bus-side signal bundle of the sleep-request controller.
//   master : system / bus-controller side (drives commands and wake sources)
//   slave  : the controller itself (drives SLEEP_REQ, WAKEUP_REQ0..2, STATE)
interface mbus_sleep_req_ctrl_if;

    logic       SYSTEM_ACTIVE;
    logic       BUS_BUSY;
    logic       SLEEP_CMD;
    logic [2:0] WAKE_SRC;
    logic [2:0] WAKE_CLR;
    logic       SLEEP_REQ;
    logic       WAKEUP_REQ0;
    logic       WAKEUP_REQ1;
    logic       WAKEUP_REQ2;
    logic [1:0] STATE;

    modport master (
        output SYSTEM_ACTIVE, BUS_BUSY, SLEEP_CMD, WAKE_SRC, WAKE_CLR,
        input  SLEEP_REQ, WAKEUP_REQ0, WAKEUP_REQ1, WAKEUP_REQ2, STATE
    );

    modport slave (
        input  SYSTEM_ACTIVE, BUS_BUSY, SLEEP_CMD, WAKE_SRC, WAKE_CLR,
        output SLEEP_REQ, WAKEUP_REQ0, WAKEUP_REQ1, WAKEUP_REQ2, STATE
    );

endinterface

// File: rtl/mbus_sleep_req_ctrl_wake_sync.sv
// One wake source: two-flop synchroniser, rising-edge detect, sticky pending.
//   CLK, rst_tran_to_wake : always-on clock, async active-high reset
//   src_i                 : raw asynchronous wake level
//   clr_i                 : synchronous clear pulse for the pending flag
//   pend_o                : registered pending wake (set wins over clear)
module mbus_wake_sync (
    input  logic CLK,
    input  logic rst_tran_to_wake,
    input  logic src_i,
    input  logic clr_i,
    output logic pend_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    // prev_q resets to 0, so a source held high through reset yields one event
    assign rise = s2_q & ~prev_q;

    always_comb begin
        pend_d = pend_q;
        if (rise) begin
            pend_d = 1'b1;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge rst_tran_to_wake) begin
        if (rst_tran_to_wake) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s1_q   <= src_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/mbus_sleep_req_ctrl.sv
// Qualifies a sleep command into SLEEP_REQ after a programmable bus-idle
// period and collects three asynchronous wake sources into sticky requests.
//   CLK, rst_tran_to_wake : always-on clock, async active-high reset
//   bus (slave)           : SYSTEM_ACTIVE, BUS_BUSY, SLEEP_CMD, WAKE_SRC,
//                           WAKE_CLR in; SLEEP_REQ, WAKEUP_REQ0..2, STATE out
module mbus_sleep_req_ctrl
    import mbus_sleep_pkg::*;
#(
    parameter int unsigned IDLE_CNT_W   = 8,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 rst_tran_to_wake,
    mbus_sleep_req_ctrl_if.slave bus
);

    localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LAST = IDLE_CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_CNT_W-1:0] CNT_ONE      = IDLE_CNT_W'(1);

    state_e                  state_q;
    state_e                  state_d;
    logic [IDLE_CNT_W-1:0]   cnt_q;
    logic [IDLE_CNT_W-1:0]   cnt_d;
    logic                    sleep_req_q;
    logic                    sleep_req_d;
    logic                    sys_act_q;
    logic [NUM_WAKE_SRC-1:0] wake_pend;
    logic                    wake_any;

    // Per-source synchroniser and sticky pending flag
    for (genvar i = 0; i < NUM_WAKE_SRC; i++) begin : g_wake
        mbus_wake_sync u_wake_sync (
            .CLK              (CLK),
            .rst_tran_to_wake (rst_tran_to_wake),
            .src_i            (bus.WAKE_SRC[i]),
            .clr_i            (bus.WAKE_CLR[i]),
            .pend_o           (wake_pend[i])
        );
    end

    assign wake_any = |wake_pend;

    // Next state and idle counter; wake_any outranks every other condition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACTIVE: begin
                if (bus.SLEEP_CMD && !wake_any) begin
                    state_d = IDLE_WAIT;
                    cnt_d   = '0;
                end
            end
            IDLE_WAIT: begin
                if (wake_any) begin
                    state_d = ACTIVE;
                end else if (bus.BUS_BUSY) begin
                    cnt_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REQ: begin
                if (wake_any) begin
                    state_d = ACTIVE;
                end else if (!bus.SYSTEM_ACTIVE) begin
                    state_d = SLEEPING;
                end
            end
            SLEEPING: begin
                // A SYSTEM_ACTIVE rise without a local wake covers external bus wakes
                if (wake_any) begin
                    state_d = ACTIVE;
                end else if (bus.SYSTEM_ACTIVE && !sys_act_q) begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    // SLEEP_REQ decoded from the next state so it is a clean flop output
    assign sleep_req_d = (state_d == REQ) || (state_d == SLEEPING);

    always_ff @(posedge CLK or posedge rst_tran_to_wake) begin
        if (rst_tran_to_wake) begin
            state_q     <= ACTIVE;
            cnt_q       <= '0;
            sleep_req_q <= 1'b0;
            sys_act_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sleep_req_q <= sleep_req_d;
            sys_act_q   <= bus.SYSTEM_ACTIVE;
        end
    end

    assign bus.SLEEP_REQ   = sleep_req_q;
    assign bus.WAKEUP_REQ0 = wake_pend[0];
    assign bus.WAKEUP_REQ1 = wake_pend[1];
    assign bus.WAKEUP_REQ2 = wake_pend[2];
    assign bus.STATE       = state_q;

endmodule

// File: tb/tb_mbus_sleep_req_ctrl.sv
// Self-checking bench: table-driven vectors on an IDLE_TIMEOUT=1 instance,
// hand-written multi-cycle sequences on the default IDLE_TIMEOUT=64 instance.
module tb_mbus_sleep_req_ctrl;

    logic CLK = 1'b0;
    logic rst_tran_to_wake;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 CLK = ~CLK;

    mbus_sleep_req_ctrl_if b64 ();
    mbus_sleep_req_ctrl_if b1 ();

    mbus_sleep_req_ctrl #(.IDLE_CNT_W(8), .IDLE_TIMEOUT(64)) u_dut64 (
        .CLK              (CLK),
        .rst_tran_to_wake (rst_tran_to_wake),
        .bus              (b64)
    );

    mbus_sleep_req_ctrl #(.IDLE_CNT_W(8), .IDLE_TIMEOUT(1)) u_dut1 (
        .CLK              (CLK),
        .rst_tran_to_wake (rst_tran_to_wake),
        .bus              (b1)
    );

    typedef struct {
        logic       sa;
        logic       busy;
        logic       cmd;
        logic [2:0] src;
        logic [2:0] clr;
        logic [1:0] st;
        logic       sreq;
        logic [2:0] wk;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic sa, logic busy, logic cmd, logic [2:0] src,
                                logic [2:0] clr, logic [1:0] st, logic sreq,
                                logic [2:0] wk);
        vec_t v;
        v.sa = sa; v.busy = busy; v.cmd = cmd; v.src = src; v.clr = clr;
        v.st = st; v.sreq = sreq; v.wk = wk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [2:0] wk64();
        return {b64.WAKEUP_REQ2, b64.WAKEUP_REQ1, b64.WAKEUP_REQ0};
    endfunction

    function automatic logic [2:0] wk1();
        return {b1.WAKEUP_REQ2, b1.WAKEUP_REQ1, b1.WAKEUP_REQ0};
    endfunction

    initial begin
        logic ok;

        //          sa busy cmd src   clr   st  sreq wk
        tbl[0]  = mk(1, 0, 0, 3'b000, 3'b000, 2'd0, 0, 3'b000);
        tbl[1]  = mk(1, 0, 1, 3'b000, 3'b000, 2'd1, 0, 3'b000);
        tbl[2]  = mk(1, 1, 0, 3'b000, 3'b000, 2'd1, 0, 3'b000);
        tbl[3]  = mk(1, 0, 0, 3'b000, 3'b000, 2'd2, 1, 3'b000);
        tbl[4]  = mk(1, 0, 1, 3'b000, 3'b000, 2'd2, 1, 3'b000);
        tbl[5]  = mk(0, 0, 0, 3'b000, 3'b000, 2'd3, 1, 3'b000);
        tbl[6]  = mk(0, 1, 0, 3'b000, 3'b000, 2'd3, 1, 3'b000);
        tbl[7]  = mk(1, 0, 0, 3'b000, 3'b000, 2'd0, 0, 3'b000);
        tbl[8]  = mk(1, 0, 1, 3'b000, 3'b000, 2'd1, 0, 3'b000);
        tbl[9]  = mk(0, 0, 0, 3'b000, 3'b000, 2'd2, 1, 3'b000);
        tbl[10] = mk(0, 0, 0, 3'b000, 3'b000, 2'd3, 1, 3'b000);
        tbl[11] = mk(0, 0, 0, 3'b001, 3'b000, 2'd3, 1, 3'b000);
        tbl[12] = mk(0, 0, 0, 3'b001, 3'b000, 2'd3, 1, 3'b000);
        tbl[13] = mk(0, 0, 0, 3'b001, 3'b000, 2'd3, 1, 3'b001);
        tbl[14] = mk(0, 0, 0, 3'b001, 3'b000, 2'd0, 0, 3'b001);
        tbl[15] = mk(1, 0, 1, 3'b001, 3'b000, 2'd0, 0, 3'b001);
        tbl[16] = mk(1, 0, 0, 3'b001, 3'b001, 2'd0, 0, 3'b000);
        tbl[17] = mk(1, 0, 0, 3'b001, 3'b000, 2'd0, 0, 3'b000);
        tbl[18] = mk(1, 0, 1, 3'b000, 3'b000, 2'd1, 0, 3'b000);
        tbl[19] = mk(1, 1, 0, 3'b000, 3'b000, 2'd1, 0, 3'b000);
        tbl[20] = mk(1, 0, 0, 3'b000, 3'b000, 2'd2, 1, 3'b000);
        tbl[21] = mk(1, 0, 0, 3'b000, 3'b000, 2'd2, 1, 3'b000);

        rst_tran_to_wake = 1'b1;
        b64.SYSTEM_ACTIVE = 1'b1; b64.BUS_BUSY = 1'b0; b64.SLEEP_CMD = 1'b0;
        b64.WAKE_SRC = 3'b000;    b64.WAKE_CLR = 3'b000;
        b1.SYSTEM_ACTIVE  = 1'b1; b1.BUS_BUSY  = 1'b0; b1.SLEEP_CMD  = 1'b0;
        b1.WAKE_SRC  = 3'b000;    b1.WAKE_CLR  = 3'b000;
        #23;
        chk("rst64_state", 32'(b64.STATE), 32'd0);
        chk("rst64_sreq",  32'(b64.SLEEP_REQ), 32'd0);
        chk("rst64_wake",  32'(wk64()), 32'd0);
        chk("rst1_state",  32'(b1.STATE), 32'd0);
        rst_tran_to_wake = 1'b0;

        // Table-driven vectors on the IDLE_TIMEOUT=1 instance
        for (int i = 0; i < NVEC; i++) begin
            b1.SYSTEM_ACTIVE = tbl[i].sa;
            b1.BUS_BUSY      = tbl[i].busy;
            b1.SLEEP_CMD     = tbl[i].cmd;
            b1.WAKE_SRC      = tbl[i].src;
            b1.WAKE_CLR      = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_state", i), 32'(b1.STATE), 32'(tbl[i].st));
            chk($sformatf("vec%0d_sreq", i),  32'(b1.SLEEP_REQ), 32'(tbl[i].sreq));
            chk($sformatf("vec%0d_wake", i),  32'(wk1()), 32'(tbl[i].wk));
        end
        b1.SLEEP_CMD = 1'b0; b1.BUS_BUSY = 1'b0; b1.WAKE_CLR = 3'b000;

        // Full 64-cycle idle qualification, then sleep
        b64.SLEEP_CMD = 1'b1;
        step();
        b64.SLEEP_CMD = 1'b0;
        chk("a_enter_idle", 32'(b64.STATE), 32'd1);
        ok = 1'b1;
        for (int i = 1; i < 64; i++) begin
            step();
            if (b64.STATE !== 2'd1 || b64.SLEEP_REQ !== 1'b0) ok = 1'b0;
        end
        chk("a_idle_hold", 32'(ok), 32'd1);
        step();
        chk("a_req_state", 32'(b64.STATE), 32'd2);
        chk("a_req_sreq",  32'(b64.SLEEP_REQ), 32'd1);
        b64.SYSTEM_ACTIVE = 1'b0;
        step();
        chk("a_sleep_state", 32'(b64.STATE), 32'd3);
        chk("a_sleep_sreq",  32'(b64.SLEEP_REQ), 32'd1);

        // Wake on source 1 while sleeping
        b64.WAKE_SRC = 3'b010;
        step();
        step();
        chk("a_wake1_early", 32'(b64.WAKEUP_REQ1), 32'd0);
        step();
        chk("a_wake1_set",   32'(b64.WAKEUP_REQ1), 32'd1);
        chk("a_wake1_sreq",  32'(b64.SLEEP_REQ), 32'd1);
        step();
        chk("a_wake_sreq0",  32'(b64.SLEEP_REQ), 32'd0);
        chk("a_wake_state",  32'(b64.STATE), 32'd0);
        b64.WAKE_CLR = 3'b010;
        b64.WAKE_SRC = 3'b000;
        b64.SYSTEM_ACTIVE = 1'b1;
        step();
        b64.WAKE_CLR = 3'b000;
        chk("a_wake1_clr", 32'(b64.WAKEUP_REQ1), 32'd0);

        // Busy pulse at count 40 restarts the idle count
        b64.SLEEP_CMD = 1'b1;
        step();
        b64.SLEEP_CMD = 1'b0;
        repeat (40) step();
        chk("b_count40_state", 32'(b64.STATE), 32'd1);
        b64.BUS_BUSY = 1'b1;
        step();
        b64.BUS_BUSY = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 63; i++) begin
            step();
            if (b64.STATE !== 2'd1 || b64.SLEEP_REQ !== 1'b0) ok = 1'b0;
        end
        chk("b_no_early_req", 32'(ok), 32'd1);
        step();
        chk("b_req_sreq", 32'(b64.SLEEP_REQ), 32'd1);
        b64.SYSTEM_ACTIVE = 1'b0;
        step();
        chk("b_sleeping", 32'(b64.STATE), 32'd3);
        b64.SYSTEM_ACTIVE = 1'b1;
        step();
        chk("b_sa_rise_state", 32'(b64.STATE), 32'd0);
        chk("b_sa_rise_sreq",  32'(b64.SLEEP_REQ), 32'd0);

        // Source 0: plain clear, then clear coinciding with a new rise
        b64.WAKE_SRC = 3'b001;
        repeat (3) step();
        chk("c_wake0_set", 32'(b64.WAKEUP_REQ0), 32'd1);
        b64.WAKE_CLR = 3'b001;
        step();
        b64.WAKE_CLR = 3'b000;
        chk("c_wake0_clr", 32'(b64.WAKEUP_REQ0), 32'd0);
        b64.WAKE_SRC = 3'b000;
        repeat (3) step();
        b64.WAKE_SRC = 3'b001;
        repeat (2) step();
        b64.WAKE_CLR = 3'b001;
        step();
        b64.WAKE_CLR = 3'b000;
        chk("c_set_wins", 32'(b64.WAKEUP_REQ0), 32'd1);

        // Sleep command dropped while a wake is pending
        b64.WAKE_SRC = 3'b101;
        repeat (3) step();
        chk("d_wake2_set", 32'(b64.WAKEUP_REQ2), 32'd1);
        b64.SLEEP_CMD = 1'b1;
        step();
        b64.SLEEP_CMD = 1'b0;
        chk("d_cmd_drop_state", 32'(b64.STATE), 32'd0);
        chk("d_cmd_drop_sreq",  32'(b64.SLEEP_REQ), 32'd0);
        b64.WAKE_SRC = 3'b000;
        repeat (3) step();
        b64.WAKE_CLR = 3'b111;
        step();
        b64.WAKE_CLR = 3'b000;
        chk("d_all_clr", 32'(wk64()), 32'd0);

        // Asynchronous reset in REQ with a wake pending
        b64.SLEEP_CMD = 1'b1;
        step();
        b64.SLEEP_CMD = 1'b0;
        repeat (64) step();
        chk("e_in_req", 32'(b64.STATE), 32'd2);
        b64.WAKE_SRC = 3'b001;
        repeat (3) step();
        chk("e_pre_state", 32'(b64.STATE), 32'd2);
        chk("e_pre_wake0", 32'(b64.WAKEUP_REQ0), 32'd1);
        #2;
        rst_tran_to_wake = 1'b1;
        #1;
        chk("e_rst_state", 32'(b64.STATE), 32'd0);
        chk("e_rst_sreq",  32'(b64.SLEEP_REQ), 32'd0);
        chk("e_rst_wake",  32'(wk64()), 32'd0);
        #3;
        rst_tran_to_wake = 1'b0;
        repeat (3) step();
        chk("e_held_src_event", 32'(b64.WAKEUP_REQ0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mbus_sleep_req_ctrl.md
Name: mbus_sleep_req_ctrl

Overview:
- Upstream companion to the MBus master sleep controller.
- Turns a software/bus-controller sleep command into a qualified SLEEP_REQ. The request is issued only after the bus has been idle for a programmable number of cycles.
- Synchronises three asynchronous wake sources into sticky WAKEUP_REQ0..2 levels that the sleep controller consumes.
- Runs on the always-on CLK domain, which is never gated by MBC_SLEEP.

Parameters:
- IDLE_CNT_W, 8, width of the bus-idle counter.
- IDLE_TIMEOUT, 64, consecutive non-busy cycles required before SLEEP_REQ. Legal range is 1..2^IDLE_CNT_W-1.

Ports:
- CLK  input  1  always-on clock.
- rst_tran_to_wake  input  1  reset, asynchronous, active-high.
- SYSTEM_ACTIVE  input  1  from the sleep controller; 1 = MBus interface awake or not isolated.
- BUS_BUSY  input  1  synchronous; 1 = MBus transaction in progress.
- SLEEP_CMD  input  1  synchronous single-cycle pulse requesting sleep.
- WAKE_SRC  input  3  raw asynchronous wake levels.
- WAKE_CLR  input  3  synchronous per-source clear pulses.
- SLEEP_REQ  output  1  registered sleep request to the sleep controller.
- WAKEUP_REQ0  output  1  registered pending wake, source 0.
- WAKEUP_REQ1  output  1  registered pending wake, source 1.
- WAKEUP_REQ2  output  1  registered pending wake, source 2.
- STATE  output  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, active-high on rst_tran_to_wake):
  - State = ACTIVE, SLEEP_REQ = 0, WAKEUP_REQ0..2 = 0.
  - Idle counter = 0; all sync and edge flops = 0.
  - Applies identically when asserted mid-operation in any state.
- Wake path (per source i):
  - Two-flop synchroniser s1 -> s2, plus a previous-value flop prev.
  - Edge condition: rise_i = s2 & ~prev.
  - pending_i is set on rise_i and cleared on WAKE_CLR[i]. If both occur in the same cycle, set wins.
  - WAKEUP_REQi = pending_i, driven directly from the flop.
  - Latency: WAKE_SRC[i] captured by s1 at CLK edge k gives WAKEUP_REQi = 1 after edge k+2.
  - A source held high across reset release produces one wake event.
  - Pulses shorter than one CLK period may be lost; the required minimum source pulse width is 2 CLK periods.
- wake_any = WAKEUP_REQ0 | WAKEUP_REQ1 | WAKEUP_REQ2.
- FSM encoding: ACTIVE = 0, IDLE_WAIT = 1, REQ = 2, SLEEPING = 3.
- ACTIVE:
  - SLEEP_CMD & ~wake_any -> IDLE_WAIT, counter cleared.
  - SLEEP_CMD while wake_any = 1 is dropped.
- IDLE_WAIT:
  - wake_any -> ACTIVE (abort).
  - Else BUS_BUSY -> counter = 0.
  - Else if counter == IDLE_TIMEOUT-1 -> REQ.
  - Else counter increments.
  - Counter never wraps. With IDLE_TIMEOUT = 1, the first non-busy cycle moves to REQ.
- REQ:
  - wake_any -> ACTIVE.
  - Else ~SYSTEM_ACTIVE -> SLEEPING.
- SLEEPING:
  - wake_any -> ACTIVE.
  - SYSTEM_ACTIVE rising with no wake pending (e.g. external MBus DIN wake) -> ACTIVE.
- SLEEP_REQ is a dedicated flop updated on the same edge as the state register, with value 1 when the next state is REQ or SLEEPING. It is glitch-free.
- SLEEP_CMD outside ACTIVE is ignored.
- Priority within a cycle: reset > wake_any > BUS_BUSY > counter/timeout > SYSTEM_ACTIVE.
- BUS_BUSY has no effect outside IDLE_WAIT.

Decomposition:
- Package mbus_sleep_pkg holds:
  - the state enum (ACTIVE / IDLE_WAIT / REQ / SLEEPING, 2-bit);
  - NUM_WAKE_SRC = 3.
- Sub-module mbus_wake_sync covers one source: synchroniser, edge detect, sticky pending and clear. It is instantiated three times.
- The FSM and idle counter live in the top module.

Test Plan:
- Reset, then SLEEP_CMD pulse with BUS_BUSY = 0 and IDLE_TIMEOUT = 64 -> STATE = 1 for 64 cycles, then SLEEP_REQ = 1. Drop SYSTEM_ACTIVE -> STATE = 3, SLEEP_REQ stays 1.
- In IDLE_WAIT, pulse BUS_BUSY at count 40 -> counter restarts at 0; SLEEP_REQ asserts 64 non-busy cycles after the busy pulse, not before.
- In SLEEPING, raise WAKE_SRC[1] -> WAKEUP_REQ1 = 1 two edges after capture and SLEEP_REQ = 0 on the next edge. WAKE_CLR[1] then clears WAKEUP_REQ1.
- WAKE_CLR[0] in the same cycle as a new rise on source 0 -> WAKEUP_REQ0 remains 1.
- SLEEP_CMD while WAKEUP_REQ2 = 1 -> STATE stays 0, SLEEP_REQ stays 0.
- Assert rst_tran_to_wake asynchronously mid-REQ with WAKEUP_REQ0 = 1 -> SLEEP_REQ = 0, all WAKEUP_REQ = 0, STATE = 0 immediately, without waiting for CLK.
